// File: rtl/control_pipe.sv
// control_pipe: control-bundle pipeline for the five-stage MIPS core.
// Carries decoder WB/M/EX bundles through ID/EX, EX/MEM and MEM/WB, and
// owns the load-use stall, branch-flush squashing and EX forwarding selects.
//
// Optional feature macro: CTRL_PIPE_FWD_EN
//   defined   -> EX operand forwarding active, only load-use hazards stall
//   undefined -> fwd_a/fwd_b tied to 00, any RAW hazard against EX or MEM stalls
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_wb/id_m/id_ex          decoder bundles {RegWrite,MemToReg} {Branch,MemRead,MemWrite}
//                             {RegDest,ALUOp[1:0],ALUSrc}
//   id_rs/id_rt/id_rd         register fields of the instruction in ID
//   flush                     branch taken (resolved in MEM)
//   ex_*                      EX-stage controls and source registers
//   mem_*                     MEM-stage controls and destination register
//   wb_*                      WB-stage controls and destination register
//   stall                     freeze PC and IF/ID (combinational)
//   fwd_a/fwd_b               EX operand selects 00 regfile, 10 EX/MEM, 01 MEM/WB (combinational)
module control_pipe #(
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    id_wb,
    input  logic [2:0]    id_m,
    input  logic [3:0]    id_ex,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    output logic          ex_alu_src,
    output logic [1:0]    ex_alu_op,
    output logic          ex_reg_dst,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic          mem_branch,
    output logic          mem_read,
    output logic          mem_write,
    output logic [RW-1:0] mem_dst,
    output logic          wb_reg_write,
    output logic          wb_mem_to_reg,
    output logic [RW-1:0] wb_dst,
    output logic          stall,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
);

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

    // Bundle bit positions
    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned M_BRANCH    = 2;
    localparam int unsigned M_MEMREAD   = 1;
    localparam int unsigned M_MEMWRITE  = 0;
    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUSRC   = 0;

    // ID/EX
    logic [WB_W-1:0] r_idex_wb;
    logic [M_W-1:0]  r_idex_m;
    logic [EX_W-1:0] r_idex_ex;
    logic [RW-1:0]   r_idex_rs;
    logic [RW-1:0]   r_idex_rt;
    logic [RW-1:0]   r_idex_rd;
    // EX/MEM
    logic [WB_W-1:0] r_exmem_wb;
    logic [M_W-1:0]  r_exmem_m;
    logic [RW-1:0]   r_exmem_dst;
    // MEM/WB
    logic [WB_W-1:0] r_memwb_wb;
    logic [RW-1:0]   r_memwb_dst;

    logic [RW-1:0] w_ex_dst;
    logic          w_stall;
    logic [1:0]    w_fwd_a;
    logic [1:0]    w_fwd_b;

    assign w_ex_dst = r_idex_ex[EX_REGDST] ? r_idex_rd : r_idex_rt;

`ifdef CTRL_PIPE_FWD_EN
    // Forwarding selects; EX/MEM is younger so it wins, $0 never forwards
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_exmem_wb[WB_REGWRITE] && (r_exmem_dst != '0) && (r_exmem_dst == r_idex_rs))
            w_fwd_a = 2'b10;
        else if (r_memwb_wb[WB_REGWRITE] && (r_memwb_dst != '0) && (r_memwb_dst == r_idex_rs))
            w_fwd_a = 2'b01;
        if (r_exmem_wb[WB_REGWRITE] && (r_exmem_dst != '0) && (r_exmem_dst == r_idex_rt))
            w_fwd_b = 2'b10;
        else if (r_memwb_wb[WB_REGWRITE] && (r_memwb_dst != '0) && (r_memwb_dst == r_idex_rt))
            w_fwd_b = 2'b01;
    end

    // Only a load in EX cannot be covered by forwarding
    assign w_stall = r_idex_m[M_MEMREAD] & ((r_idex_rt == id_rs) | (r_idex_rt == id_rt));
`else
    logic w_haz_ex;
    logic w_haz_mem;

    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;

    // Without forwarding, wait until the producer has reached WB
    assign w_haz_ex  = r_idex_wb[WB_REGWRITE] & (w_ex_dst != '0) &
                       ((w_ex_dst == id_rs) | (w_ex_dst == id_rt));
    assign w_haz_mem = r_exmem_wb[WB_REGWRITE] & (r_exmem_dst != '0) &
                       ((r_exmem_dst == id_rs) | (r_exmem_dst == id_rt));
    assign w_stall   = w_haz_ex | w_haz_mem;
`endif

    // ID/EX: bubble on stall or flush
    always_ff @(posedge clk) begin
        if (rst || flush || w_stall) begin
            r_idex_wb <= '0;
            r_idex_m  <= '0;
            r_idex_ex <= '0;
            r_idex_rs <= '0;
            r_idex_rt <= '0;
            r_idex_rd <= '0;
        end else begin
            r_idex_wb <= id_wb;
            r_idex_m  <= id_m;
            r_idex_ex <= id_ex;
            r_idex_rs <= id_rs;
            r_idex_rt <= id_rt;
            r_idex_rd <= id_rd;
        end
    end

    // EX/MEM: bubble on flush only; a stall lets the older instruction move on
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_exmem_wb  <= '0;
            r_exmem_m   <= '0;
            r_exmem_dst <= '0;
        end else begin
            r_exmem_wb  <= r_idex_wb;
            r_exmem_m   <= r_idex_m;
            r_exmem_dst <= w_ex_dst;
        end
    end

    // MEM/WB: always advances so a taken branch still retires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memwb_wb  <= '0;
            r_memwb_dst <= '0;
        end else begin
            r_memwb_wb  <= r_exmem_wb;
            r_memwb_dst <= r_exmem_dst;
        end
    end

    assign ex_alu_src    = r_idex_ex[EX_ALUSRC];
    assign ex_alu_op     = r_idex_ex[2:1];
    assign ex_reg_dst    = r_idex_ex[EX_REGDST];
    assign ex_rs         = r_idex_rs;
    assign ex_rt         = r_idex_rt;
    assign mem_branch    = r_exmem_m[M_BRANCH];
    assign mem_read      = r_exmem_m[M_MEMREAD];
    assign mem_write     = r_exmem_m[M_MEMWRITE];
    assign mem_dst       = r_exmem_dst;
    assign wb_reg_write  = r_memwb_wb[WB_REGWRITE];
    assign wb_mem_to_reg = r_memwb_wb[WB_MEMTOREG];
    assign wb_dst        = r_memwb_dst;
    assign stall         = w_stall;
    assign fwd_a         = w_fwd_a;
    assign fwd_b         = w_fwd_b;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe. Each step pushes the outputs it expects
// (cycle, field, value) into a scoreboard queue; entries are popped and
// compared when the simulation reaches their cycle.
module tb_control_pipe;

    localparam int unsigned RW = 5;

    localparam int F_EX    = 0;  // {reg_dst, alu_op, alu_src}
    localparam int F_EXRS  = 1;
    localparam int F_EXRT  = 2;
    localparam int F_MEM   = 3;  // {branch, read, write}
    localparam int F_MDST  = 4;
    localparam int F_WB    = 5;  // {reg_write, mem_to_reg}
    localparam int F_WDST  = 6;
    localparam int F_STALL = 7;
    localparam int F_FWDA  = 8;
    localparam int F_FWDB  = 9;

    logic          clk;
    logic          rst;
    logic [1:0]    id_wb;
    logic [2:0]    id_m;
    logic [3:0]    id_ex;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic          flush;
    logic          ex_alu_src;
    logic [1:0]    ex_alu_op;
    logic          ex_reg_dst;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic          mem_branch;
    logic          mem_read;
    logic          mem_write;
    logic [RW-1:0] mem_dst;
    logic          wb_reg_write;
    logic          wb_mem_to_reg;
    logic [RW-1:0] wb_dst;
    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    control_pipe #(.RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_read(mem_read), .mem_write(mem_write),
        .mem_dst(mem_dst),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           at;
        bit [127:0]   tag;
        int           sel;
        logic [7:0]   val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            F_EX:    return 8'({ex_reg_dst, ex_alu_op, ex_alu_src});
            F_EXRS:  return 8'(ex_rs);
            F_EXRT:  return 8'(ex_rt);
            F_MEM:   return 8'({mem_branch, mem_read, mem_write});
            F_MDST:  return 8'(mem_dst);
            F_WB:    return 8'({wb_reg_write, wb_mem_to_reg});
            F_WDST:  return 8'(wb_dst);
            F_STALL: return 8'(stall);
            F_FWDA:  return 8'(fwd_a);
            F_FWDB:  return 8'(fwd_b);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push(input int at, input bit [127:0] tag, input int sel, input int val);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sel = sel;
        e.val = 8'(val);
        q.push_back(e);
    endtask

    task automatic push_all_zero(input int at, input bit [127:0] tag);
        for (int s = F_EX; s <= F_FWDB; s++) push(at, tag, s, 0);
    endtask

    // Compare every queued expectation that falls due this cycle
    task automatic check_due();
        int i;
        logic [7:0] o;
        i = 0;
        while (i < q.size()) begin
            if (q[i].at == cyc) begin
                o = obs(q[i].sel);
                checks++;
                assert (o === q[i].val) else begin
                    failures++;
                    $error("FAIL %0s cycle=%0d field=%0d observed=%0h expected=%0h",
                           q[i].tag, cyc, q[i].sel, o, q[i].val);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Settle inputs, check this cycle, then advance one clock
    task automatic cycle();
        #1;
        check_due();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drv(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                       input int rs, input int rt, input int rd);
        id_wb = wb;
        id_m  = m;
        id_ex = ex;
        id_rs = RW'(rs);
        id_rt = RW'(rt);
        id_rd = RW'(rd);
    endtask

    task automatic nop();                           drv(2'b00, 3'b000, 4'b0000, 0, 0, 0);   endtask
    task automatic rtype(input int rs, rt, rd);     drv(2'b10, 3'b000, 4'b1100, rs, rt, rd); endtask
    task automatic lw(input int rs, rt);            drv(2'b11, 3'b010, 4'b0001, rs, rt, 0); endtask
    task automatic br(input int rs, rt);            drv(2'b00, 3'b100, 4'b0010, rs, rt, 0); endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) begin
            nop();
            cycle();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset with random, non-zero decoder inputs
        rst   = 1'b1;
        flush = 1'b0;
        drv(2'($urandom) | 2'b10, 3'($urandom) | 3'b010, 4'($urandom) | 4'b1000,
            int'($urandom_range(1, 31)), int'($urandom_range(1, 31)), int'($urandom_range(1, 31)));
        cycle();
        drv(2'($urandom) | 2'b10, 3'($urandom) | 3'b010, 4'($urandom) | 4'b1000,
            int'($urandom_range(1, 31)), int'($urandom_range(1, 31)), int'($urandom_range(1, 31)));
        push_all_zero(cyc, "reset1");
        cycle();

        // ---- single R-type through all stages
        rst = 1'b0;
        rtype(1, 2, 3);
        push_all_zero(cyc, "reset2");
        push(cyc + 1, "r_ex",    F_EX,   4'b1100);
        push(cyc + 1, "r_exrs",  F_EXRS, 1);
        push(cyc + 1, "r_exrt",  F_EXRT, 2);
        push(cyc + 2, "r_mem",   F_MEM,  0);
        push(cyc + 2, "r_mdst",  F_MDST, 3);
        push(cyc + 3, "r_wb",    F_WB,   2'b10);
        push(cyc + 3, "r_wdst",  F_WDST, 3);
        cycle();
        nop();
        push(cyc, "r_nostall", F_STALL, 0);
        cycle();
        nops(3);

        // ---- load-use: lw $2 then add rs=2
        lw(0, 2);
        push(cyc + 1, "lw_ex",   F_EX,   4'b0001);
        push(cyc + 1, "lw_exrt", F_EXRT, 2);
        cycle();
        rtype(2, 7, 8);
        push(cyc, "lu_stall", F_STALL, 1);
        cycle();
        rtype(2, 7, 8);
        push(cyc, "lu_bub_ex", F_EX,   0);
        push(cyc, "lu_bub_rt", F_EXRT, 0);
        push(cyc, "lu_lw_mem", F_MEM,  3'b010);
`ifdef CTRL_PIPE_FWD_EN
        push(cyc, "lu_stall_off", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "lu_add_rs", F_EXRS,  2);
        push(cyc, "lu_fwd_a",  F_FWDA,  2'b01);
        push(cyc, "lu_stall0", F_STALL, 0);
        cycle();
`else
        push(cyc, "lu_stall2", F_STALL, 1);
        cycle();
        rtype(2, 7, 8);
        push(cyc, "lu_stall_off", F_STALL, 0);
        push(cyc, "lu_bub2_ex",   F_EX,    0);
        cycle();
        nop();
        push(cyc, "lu_add_rs", F_EXRS, 2);
        push(cyc, "lu_fwd_a",  F_FWDA, 0);
        cycle();
`endif
        nops(3);

        // ---- add $4 then sub rs=4 back to back
        rtype(1, 1, 4);
        cycle();
        rtype(4, 5, 6);
`ifdef CTRL_PIPE_FWD_EN
        push(cyc, "b2b_nostall", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "b2b_exrs",  F_EXRS, 4);
        push(cyc, "b2b_fwd_a", F_FWDA, 2'b10);
        push(cyc, "b2b_fwd_b", F_FWDB, 2'b00);
        cycle();
`else
        push(cyc, "b2b_stall1", F_STALL, 1);
        push(cyc, "b2b_fwd_a1", F_FWDA,  0);
        cycle();
        rtype(4, 5, 6);
        push(cyc, "b2b_stall2", F_STALL, 1);
        push(cyc, "b2b_fwd_a2", F_FWDA,  0);
        cycle();
        rtype(4, 5, 6);
        push(cyc, "b2b_stall3", F_STALL, 0);
        push(cyc, "b2b_fwd_a3", F_FWDA,  0);
        cycle();
        nop();
        push(cyc, "b2b_exrs",  F_EXRS, 4);
        push(cyc, "b2b_fwd_a", F_FWDA, 0);
        cycle();
`endif
        nops(3);

        // ---- add $4, independent, sub rs=4 rt=4
        rtype(1, 1, 4);
        cycle();
        rtype(1, 1, 9);
        cycle();
        rtype(4, 4, 6);
`ifdef CTRL_PIPE_FWD_EN
        push(cyc, "gap_nostall", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "gap_fwd_a", F_FWDA, 2'b01);
        push(cyc, "gap_fwd_b", F_FWDB, 2'b01);
        cycle();
`else
        push(cyc, "gap_stall", F_STALL, 1);
        cycle();
        rtype(4, 4, 6);
        push(cyc, "gap_stall_off", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "gap_exrs",  F_EXRS, 4);
        push(cyc, "gap_fwd_a", F_FWDA, 0);
        push(cyc, "gap_fwd_b", F_FWDB, 0);
        cycle();
`endif
        nops(3);

        // ---- writes to $0 never forward or stall
        rtype(1, 1, 0);
        cycle();
        rtype(1, 1, 0);
        cycle();
        rtype(0, 0, 6);
        push(cyc, "r0_nostall", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "r0_wb",    F_WB,   2'b10);
        push(cyc, "r0_fwd_a", F_FWDA, 0);
        push(cyc, "r0_fwd_b", F_FWDB, 0);
        cycle();
        nops(3);

        // ---- both EX/MEM and MEM/WB write $5, consumer reads $5
        rtype(1, 1, 5);
        cycle();
        rtype(2, 2, 5);
        cycle();
        rtype(5, 3, 6);
`ifdef CTRL_PIPE_FWD_EN
        push(cyc, "r5_nostall", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "r5_fwd_a", F_FWDA, 2'b10);
        push(cyc, "r5_fwd_b", F_FWDB, 2'b00);
        cycle();
`else
        push(cyc, "r5_stall1", F_STALL, 1);
        cycle();
        rtype(5, 3, 6);
        push(cyc, "r5_stall2", F_STALL, 1);
        cycle();
        rtype(5, 3, 6);
        push(cyc, "r5_stall3", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "r5_exrs",  F_EXRS, 5);
        push(cyc, "r5_fwd_a", F_FWDA, 0);
        cycle();
`endif
        nops(3);

        // ---- branch in MEM flushes; load in EX and dependent in ID
        br(1, 6);
        cycle();
        lw(3, 2);
        push(cyc, "fl_nostall", F_STALL, 0);
        cycle();
        rtype(2, 3, 4);
        flush = 1'b1;
        push(cyc, "fl_br_mem", F_MEM,   3'b100);
        push(cyc, "fl_stall",  F_STALL, 1);
        cycle();
        flush = 1'b0;
        nop();
        push(cyc, "fl_ex",    F_EX,    0);
        push(cyc, "fl_exrs",  F_EXRS,  0);
        push(cyc, "fl_exrt",  F_EXRT,  0);
        push(cyc, "fl_mem",   F_MEM,   0);
        push(cyc, "fl_mdst",  F_MDST,  0);
        push(cyc, "fl_wb",    F_WB,    0);
        push(cyc, "fl_wdst",  F_WDST,  6);
        push(cyc, "fl_stall0", F_STALL, 0);
        cycle();
        nop();
        push(cyc, "fl_wdst2", F_WDST, 0);
        cycle();
        nops(2);

        // ---- reset mid-operation, overriding a flush
        rtype(1, 2, 7);
        cycle();
        rtype(3, 4, 8);
        cycle();
        rst   = 1'b1;
        flush = 1'b1;
        rtype(5, 6, 9);
        cycle();
        rst   = 1'b0;
        flush = 1'b0;
        rtype(1, 2, 10);
        push_all_zero(cyc, "rst_mid");
        cycle();
        nop();
        push(cyc, "rst_ex",   F_EX,   4'b1100);
        push(cyc, "rst_exrs", F_EXRS, 1);
        push(cyc, "rst_exrt", F_EXRT, 2);
        push(cyc, "rst_mem",  F_MEM,  0);
        push(cyc, "rst_mdst", F_MDST, 0);
        push(cyc, "rst_wb",   F_WB,   0);
        cycle();
        nop();
        push(cyc, "rst_mdst2", F_MDST, 10);
        cycle();
        nops(1);

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Control-bundle pipeline for the five-stage MIPS core: consumes the decoder's WB/M/EX bundles in ID and carries them through the ID/EX, EX/MEM and MEM/WB stage registers, fanning each field out to the stage that uses it. It also owns the hazard logic that acts on those bundles:
- load-use stall detection and bubble insertion;
- branch-flush squashing;
- EX operand forwarding selects.

## Interface
Parameters:
- RW, 5, register-number width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_wb  in  2  {RegWrite, MemToReg} from decoder
- id_m  in  3  {Branch, MemRead, MemWrite} from decoder
- id_ex  in  4  {RegDest, ALUOp[1:0], ALUSrc} from decoder
- id_rs, id_rt, id_rd  in  RW  register fields of instruction in ID
- flush  in  1  branch taken, resolved in MEM
- ex_alu_src  out  1, ex_alu_op  out  2, ex_reg_dst  out  1  EX-stage controls
- ex_rs, ex_rt  out  RW  source registers of instruction in EX
- mem_branch, mem_read, mem_write  out  1 each  MEM-stage controls
- mem_dst  out  RW  destination register in MEM
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
- wb_dst  out  RW  destination register in WB
- stall  out  1  freeze PC and IF/ID; combinational
- fwd_a, fwd_b  out  2  EX operand source selects: 00 regfile, 10 EX/MEM, 01 MEM/WB; combinational

## Operation
**Stage registers.** ID/EX holds wb, m, ex, rs, rt and rd. EX/MEM holds wb, m and dst. MEM/WB holds wb and dst.

**Destination select.** In EX: dst = RegDest ? rd : rt. This value is latched into EX/MEM.dst.

**Bubble.** All control bits zero; register fields don't-care but cleared to 0.

**Load-use stall.**
- stall = ID/EX.MemRead & (ex_rt == id_rs | ex_rt == id_rt).
- On stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.

**Flush.**
- On flush: ID/EX and EX/MEM load bubbles (squashes the two younger instructions).
- MEM/WB advances normally, so the branch itself retires.
- flush has priority over stall.
- stall is still driven combinationally during flush; the IF side ORs flush into its own kill.

**Forwarding, operand A (same rule for B using ex_rt).**
- 10 if EX/MEM.RegWrite & mem_dst != 0 & mem_dst == ex_rs.
- Else 01 if MEM/WB.RegWrite & wb_dst != 0 & wb_dst == ex_rs.
- Else 00.
- EX/MEM wins over MEM/WB when both match.
- Register 0 never forwards.

**Register file.** Writes in the first half of the cycle and reads in the second, so WB needs no hazard handling here.

## Timing
- **Reset:** every stage register cleared on the first rising edge with rst=1. All outputs are then 0, including stall=0 and fwd_a=fwd_b=00. Reset overrides flush and stall.
- **Reset mid-operation:** all in-flight instructions are discarded. The first post-reset edge with rst=0 loads ID/EX from the id_* inputs normally.
- **Latency:** a bundle presented in ID during cycle n appears on ex_* in cycle n+1, on mem_* in n+2, and on wb_* in n+3.
- **Stall** is asserted in the same cycle the load is in EX and the dependent instruction is in ID. It deasserts the next cycle, because the load has moved to MEM and the bubble occupies EX. The dependent instruction then gets fwd=01 when it reaches EX.
- **Consecutive loads:** each is evaluated independently. Since the bubble has MemRead=0, a stall never exceeds 1 cycle per load.
- **Flush and stall in the same cycle:** bubbles go to ID/EX and EX/MEM; stall output unchanged.

## Configuration
- **CTRL_PIPE_FWD_EN defined:** forwarding as described; only load-use hazards stall.
- **CTRL_PIPE_FWD_EN undefined:**
  - fwd_a and fwd_b are tied to 00.
  - stall is asserted for any RAW hazard, i.e. when (ID/EX.RegWrite & ex_dst != 0) or (EX/MEM.RegWrite & mem_dst != 0) has a destination equal to id_rs or id_rt.
  - Insertion behaviour and flush priority are unchanged.

## Test plan
- rst=1 for 2 cycles with random id_* inputs -> all outputs 0. Then R-type id_wb=10, id_m=000, id_ex=1100, rd=3 -> ex_* =1,10,0 in n+1; mem_dst=3 in n+2; wb_reg_write=1, wb_dst=3 in n+3.
- lw $2 (MemRead=1, RegDest=0, rt=2) followed by add with rs=2 in ID -> stall=1 for exactly 1 cycle and a bubble in EX. When the add reaches EX, fwd_a=01.
- add $4 then sub rs=4 back-to-back -> fwd_a=10, no stall. Same case with one independent instruction between -> fwd_a=01.
- Writes to $0 in EX/MEM and MEM/WB, consumer rs=0 -> fwd_a=00. Both stages write $5 and the consumer reads $5 -> fwd_a=10.
- Branch in MEM with flush=1, a load in EX and a dependent instruction in ID -> next cycle ID/EX and EX/MEM controls all 0, and the branch appears in WB.
- With CTRL_PIPE_FWD_EN undefined: add $4 then sub rs=4 -> stall=1 for 2 cycles, fwd_a=00 throughout.
